// File: rtl/inst_sched_pkg.sv
// inst_sched_pkg: shared types and constants for the instruction display scheduler.
//   state_e     : scheduler FSM states
//   SYM_W/N_SYM : symbol width and symbols per message
//   INST_W      : display register width
//   MSG_*       : message indices into the message ROM
package inst_sched_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_e;
    localparam int SYM_W  = 5;
    localparam int N_SYM  = 8;
    localparam int INST_W = SYM_W * N_SYM;
    localparam logic [2:0] MSG_TRANSFER = 3'd0;
    localparam logic [2:0] MSG_DEPOSIT  = 3'd1;
    localparam logic [2:0] MSG_WITHDRAW = 3'd2;
    localparam logic [2:0] MSG_BALANCE  = 3'd3;
    localparam logic [2:0] MSG_PIN      = 3'd4;
    localparam logic [2:0] MSG_ERROR    = 3'd5;
    localparam logic [2:0] MSG_THANKYOU = 3'd6;
    localparam logic [2:0] MSG_BLANK    = 3'd7;
endpackage

// File: rtl/inst_sched_if.sv
// inst_sched_if: requester/scheduler bundle for the shared instruction display.
//   req, msg_id            : requester -> scheduler (msg_id slice [3i+2:3i] belongs to req[i])
//   grant, busy, sym_valid,
//   done, instruction      : scheduler -> requesters
//   master modport = requester side, slave modport = scheduler side
interface inst_sched_if #(parameter int N_REQ = 4);
    import inst_sched_pkg::*;
    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] msg_id;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic               sym_valid;
    logic               done;
    logic [INST_W-1:0]  instruction;
    modport master (output req, msg_id, input grant, busy, sym_valid, done, instruction);
    modport slave  (input req, msg_id, output grant, busy, sym_valid, done, instruction);
endinterface

// File: rtl/inst_msg_rom.sv
// inst_msg_rom: combinational 8 x 8-symbol message table (0=blank, 1..26=A..Z).
//   msg : message index
//   idx : symbol position, 0 = leftmost
//   sym : symbol code
module inst_msg_rom
    import inst_sched_pkg::*;
(
    input  logic [2:0]       msg,
    input  logic [2:0]       idx,
    output logic [SYM_W-1:0] sym
);
    // Each row is packed leftmost symbol first, exactly as it appears on the display.
    localparam logic [N_SYM-1:0][INST_W-1:0] ROM = {
        40'd0,
        {5'd20, 5'd8,  5'd1,  5'd14, 5'd11, 5'd25, 5'd15, 5'd21},
        {5'd5,  5'd18, 5'd18, 5'd15, 5'd18, 5'd0,  5'd0,  5'd0 },
        {5'd16, 5'd9,  5'd14, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0 },
        {5'd2,  5'd1,  5'd12, 5'd1,  5'd14, 5'd3,  5'd5,  5'd0 },
        {5'd23, 5'd9,  5'd20, 5'd8,  5'd4,  5'd18, 5'd1,  5'd23},
        {5'd4,  5'd5,  5'd16, 5'd15, 5'd19, 5'd9,  5'd20, 5'd0 },
        {5'd20, 5'd18, 5'd1,  5'd14, 5'd19, 5'd6,  5'd5,  5'd18}
    };
    assign sym = ROM[msg][SYM_W*(N_SYM-1-int'(idx)) +: SYM_W];
endmodule

// File: rtl/inst_scheduler.sv
// inst_scheduler: round-robin owner of the 40-bit instruction display register.
//   sec_clock : display tick clock
//   rst       : synchronous active-high reset
//   bus       : inst_sched_if.slave (req/msg_id in; grant/busy/sym_valid/done/instruction out)
// Per grant: clear the register, shift in 8 symbols, hold HOLD_CYCLES, pulse done.
// Build option INST_SCHED_SCROLL_EN: rotate the display left one symbol per HOLD cycle.
module inst_scheduler
    import inst_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input logic         sec_clock,
    input logic         rst,
    inst_sched_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int HC_W  = $clog2(HOLD_CYCLES + 1);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [2:0]         msg_q, msg_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [2:0]         sym_cnt_q, sym_cnt_d;
    logic [HC_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [INST_W-1:0]  instruction_q, instruction_d;
    logic [SYM_W-1:0]   sym;
    logic [PTR_W-1:0]   win;
    logic               found;

    inst_msg_rom rom_i (.msg(msg_q), .idx(sym_cnt_q), .sym(sym));

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        msg_d         = msg_q;
        rr_ptr_d      = rr_ptr_q;
        sym_cnt_d     = sym_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        instruction_d = instruction_q;
        win           = '0;
        found         = 1'b0;
        // First active request at or above rr_ptr, wrapping around.
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && bus.req[(int'(rr_ptr_q) + i) % N_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((int'(rr_ptr_q) + i) % N_REQ);
            end
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = CLEAR;
                    grant_d  = N_REQ'(1) << win;
                    msg_d    = bus.msg_id[3*int'(win) +: 3];
                    rr_ptr_d = PTR_W'((int'(win) + 1) % N_REQ);
                end
            end
            CLEAR: begin
                instruction_d = '0;
                sym_cnt_d     = '0;
                state_d       = SHIFT;
            end
            SHIFT: begin
                instruction_d = {instruction_q[INST_W-SYM_W-1:0], sym};
                if (sym_cnt_q == 3'(N_SYM - 1)) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end else begin
                    sym_cnt_d = sym_cnt_q + 3'd1;
                end
            end
            HOLD: begin
`ifdef INST_SCHED_SCROLL_EN
                instruction_d = {instruction_q[INST_W-SYM_W-1:0], instruction_q[INST_W-1 -: SYM_W]};
`else
                instruction_d = instruction_q;
`endif
                hold_cnt_d = hold_cnt_q + HC_W'(1);
                if (hold_cnt_q == HC_W'(HOLD_CYCLES - 1)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sec_clock) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            msg_q         <= '0;
            rr_ptr_q      <= '0;
            sym_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            instruction_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            msg_q         <= msg_d;
            rr_ptr_q      <= rr_ptr_d;
            sym_cnt_q     <= sym_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            instruction_q <= instruction_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.sym_valid   = state_q == SHIFT;
    assign bus.done        = state_q == DONE;
    assign bus.instruction = instruction_q;
endmodule

// File: tb/tb_inst_scheduler.sv
// tb_inst_scheduler: directed self-checking bench for inst_scheduler (N_REQ=4, HOLD_CYCLES=4).
module tb_inst_scheduler;
    import inst_sched_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    inst_sched_if #(.N_REQ(4)) bus ();
    inst_scheduler #(.N_REQ(4), .HOLD_CYCLES(4)) dut (.sec_clock(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] pack8(input logic [4:0] s0, s1, s2, s3, s4, s5, s6, s7);
        return {s0, s1, s2, s3, s4, s5, s6, s7};
    endfunction

    // Entered right after the grant edge (state CLEAR). Follows the service to done and one cycle past it.
    task automatic serve(input string tag, input logic [39:0] full, input logic [3:0] gnt, input int drop_at);
        int cyc = 0;
        int sv  = 0;
        logic [39:0] at_done;
`ifdef INST_SCHED_SCROLL_EN
        at_done = {full[19:0], full[39:20]};
`else
        at_done = full;
`endif
        while (bus.done !== 1'b1 && cyc < 40) begin
            tick;
            cyc++;
            if (bus.sym_valid === 1'b1) sv++;
            if (cyc == drop_at) begin
                bus.req    = '0;
                bus.msg_id = '0;
            end
            if (cyc == 2) chk({tag, " first_sym"}, bus.instruction, {35'd0, full[39:35]});
            if (cyc == 9) chk({tag, " full_msg"}, bus.instruction, full);
        end
        chk({tag, " done_latency"}, cyc, 13);
        chk({tag, " sym_valid_cnt"}, sv, 8);
        chk({tag, " inst_at_done"}, bus.instruction, at_done);
        chk({tag, " grant_at_done"}, bus.grant, gnt);
        tick;
        chk({tag, " done_pulse"}, bus.done, 1'b0);
        chk({tag, " grant_after"}, bus.grant, 4'b0000);
        chk({tag, " busy_after"}, bus.busy, 1'b0);
        chk({tag, " inst_kept"}, bus.instruction, at_done);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] order [5];
        logic [39:0] thanks, deposit;
        order   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        thanks  = pack8(20, 8, 1, 14, 11, 25, 15, 21);
        deposit = pack8(4, 5, 16, 15, 19, 9, 20, 0);
        bus.req    = '0;
        bus.msg_id = '0;
        do_reset;
        chk("rst instruction", bus.instruction, 40'd0);
        chk("rst grant", bus.grant, 4'b0000);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst sym_valid", bus.sym_valid, 1'b0);
        chk("rst done", bus.done, 1'b0);

        // TRANSFER from requester 0
        bus.req    = 4'b0001;
        bus.msg_id = 12'h000;
        tick;
        chk("t1 grant", bus.grant, 4'b0001);
        chk("t1 busy", bus.busy, 1'b1);
        bus.req = '0;
        serve("t1", 40'hA482E998B2, 4'b0001, 0);

        // all four requesting THANKYOU: round-robin from 0
        do_reset;
        bus.req    = 4'b1111;
        bus.msg_id = 12'hDB6;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("t2 grant%0d", k), bus.grant, order[k]);
            serve($sformatf("t2 svc%0d", k), thanks, order[k], 0);
        end
        bus.req = '0;

        // requester 2 drops req and changes msg_id mid-shift
        bus.req    = 4'b0100;
        bus.msg_id = 12'(1) << 6;
        tick;
        chk("t3 grant", bus.grant, 4'b0100);
        serve("t3", deposit, 4'b0100, 3);

        // reset during the 5th SHIFT cycle; pointer restarts at 0
        bus.req    = 4'b0010;
        bus.msg_id = 12'(3) << 3;
        tick;
        chk("t4 grant", bus.grant, 4'b0010);
        for (int k = 0; k < 5; k++) tick;
        chk("t4 in_shift", bus.sym_valid, 1'b1);
        rst        = 1'b1;
        bus.req    = 4'b1001;
        bus.msg_id = 12'h004;
        tick;
        chk("t4 rst instruction", bus.instruction, 40'd0);
        chk("t4 rst grant", bus.grant, 4'b0000);
        chk("t4 rst busy", bus.busy, 1'b0);
        chk("t4 rst sym_valid", bus.sym_valid, 1'b0);
        rst = 1'b0;
        tick;
        chk("t4 regrant", bus.grant, 4'b0001);
        bus.req = '0;

        // PIN message on requester 0
        serve("t5", 40'h825C000000, 4'b0001, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
